// File: rtl/rv_pkg.sv
// Shared RISC-V decode constants and helpers for the memory stage and the
// write-back / cache path.
package rv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // True when a load/store has a defined funct3 and its address is
    // naturally aligned for the access size.
    function automatic logic mem_op_legal(input logic       is_store,
                                          input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b0;
        if (is_store) begin
            case (funct3)
                F3_SB:   ok = 1'b1;
                F3_SH:   ok = ~addr_lo[0];
                F3_SW:   ok = (addr_lo == 2'b00);
                default: ok = 1'b0;
            endcase
        end else begin
            case (funct3)
                F3_LB, F3_LBU: ok = 1'b1;
                F3_LH, F3_LHU: ok = ~addr_lo[0];
                F3_LW:         ok = (addr_lo == 2'b00);
                default:       ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/memory_stage_load_align.sv
// Load data alignment: picks the byte/half lane addressed by addr[1:0] out of
// a 32-bit memory word and sign- or zero-extends it according to funct3.
module load_align
    import rv_pkg::*;
(
    input  logic [31:0] mem_rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Lane select then extension.
    always_comb begin
        case (addr)
            2'd0: byte_lane = mem_rdata[7:0];
            2'd1: byte_lane = mem_rdata[15:8];
            2'd2: byte_lane = mem_rdata[23:16];
            2'd3: byte_lane = mem_rdata[31:24];
        endcase
        half_lane = addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3)
            F3_LB:   data = {{24{byte_lane[7]}}, byte_lane};
            F3_LBU:  data = {24'h0, byte_lane};
            F3_LH:   data = {{16{half_lane[15]}}, half_lane};
            F3_LHU:  data = {16'h0, half_lane};
            default: data = mem_rdata;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// Memory stage: retires execute results, performs loads/stores over a
// request/ready port, resolves branch/jump redirection and holds execute
// (stall) while a data access is outstanding.
module memory_stage
    import rv_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] IR,
    input  logic [31:0] ALU,
    input  logic        COMP,
    input  logic [31:0] PC,
    input  logic [31:0] B,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    output logic [31:0] IR_out,
    output logic [31:0] WB_out,
    output logic [31:0] PC_out,
    output logic        br_taken,
    output logic [31:0] br_target,
    output logic        misalign,
    output logic        bus_err
);

    // Counter value on the last ACCESS cycle allowed without mem_ready.
    localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    state_t      state;
    logic [31:0] cnt;
    logic [31:0] ir_q;
    logic [31:0] pc_q;
    logic [1:0]  addr_lo_q;
    logic [31:0] load_data;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        is_load;
    logic        is_store;
    logic        legal;

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            F3_SB:   return 4'b0001 << lo;
            F3_SH:   return 4'b0011 << lo;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] b);
        case (f3)
            F3_SB:   return {4{b[7:0]}};
            F3_SH:   return {2{b[15:0]}};
            default: return b;
        endcase
    endfunction

    assign stall = (state == ACCESS);

    // Decode of the instruction currently offered by execute.
    always_comb begin
        opcode   = IR[6:0];
        funct3   = IR[14:12];
        is_load  = (opcode == OP_LOAD);
        is_store = (opcode == OP_STORE);
        legal    = mem_op_legal(is_store, funct3, ALU[1:0]);
    end

    load_align u_load_align (
        .mem_rdata (mem_rdata),
        .funct3    (ir_q[14:12]),
        .addr      (addr_lo_q),
        .data      (load_data)
    );

    // Accept / access / retire sequencing; pulse flags default low each cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            ir_q      <= '0;
            pc_q      <= '0;
            addr_lo_q <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            out_valid <= 1'b0;
            IR_out    <= '0;
            WB_out    <= '0;
            PC_out    <= RESET_PC;
            br_taken  <= 1'b0;
            br_target <= RESET_PC;
            misalign  <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            br_taken  <= 1'b0;
            misalign  <= 1'b0;
            bus_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if ((is_load || is_store) && legal) begin
                            state     <= ACCESS;
                            cnt       <= '0;
                            ir_q      <= IR;
                            pc_q      <= PC;
                            addr_lo_q <= ALU[1:0];
                            mem_req   <= 1'b1;
                            mem_we    <= is_store;
                            mem_addr  <= {ALU[31:2], 2'b00};
                            mem_be    <= is_store ? store_be(funct3, ALU[1:0]) : 4'b1111;
                            mem_wdata <= is_store ? store_data(funct3, B) : 32'h0;
                        end else begin
                            out_valid <= 1'b1;
                            IR_out    <= IR;
                            PC_out    <= PC;
                            if (is_load || is_store) begin
                                misalign <= 1'b1;
                                WB_out   <= '0;
                            end else begin
                                case (opcode)
                                    OP_JAL: begin
                                        WB_out    <= PC + 32'd4;
                                        br_taken  <= 1'b1;
                                        br_target <= ALU;
                                    end
                                    OP_JALR: begin
                                        WB_out    <= PC + 32'd4;
                                        br_taken  <= 1'b1;
                                        br_target <= {ALU[31:1], 1'b0};
                                    end
                                    OP_BRANCH: begin
                                        WB_out    <= '0;
                                        br_taken  <= COMP;
                                        br_target <= ALU;
                                    end
                                    default: WB_out <= ALU;
                                endcase
                            end
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ready) begin
                        state     <= IDLE;
                        mem_req   <= 1'b0;
                        out_valid <= 1'b1;
                        IR_out    <= ir_q;
                        PC_out    <= pc_q;
                        WB_out    <= mem_we ? 32'h0 : load_data;
                    end else if (TIMEOUT != 0 && cnt == TO_LAST) begin
                        state     <= IDLE;
                        mem_req   <= 1'b0;
                        out_valid <= 1'b1;
                        bus_err   <= 1'b1;
                        IR_out    <= ir_q;
                        PC_out    <= pc_q;
                        WB_out    <= '0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
